// File: rtl/spare_dac_serializer_if.sv
// Sample-word input and DAC pin bundle for spare_dac_serializer.
// Frame_Count/Overrun_Count exist only when SPARE_DAC_FRAME_CNT_EN is defined.
interface spare_dac_serializer_if;
    logic [11:0] Din;
    logic        Load;
    logic        DAC_CS_n;
    logic        DAC_SCLK;
    logic        DAC_SDI;
    logic        Busy;
    logic        Done;
    logic        Overrun;
`ifdef SPARE_DAC_FRAME_CNT_EN
    logic [15:0] Frame_Count;
    logic [7:0]  Overrun_Count;

    modport master (
        output Din, Load,
        input  DAC_CS_n, DAC_SCLK, DAC_SDI, Busy, Done, Overrun, Frame_Count, Overrun_Count
    );
    modport slave (
        input  Din, Load,
        output DAC_CS_n, DAC_SCLK, DAC_SDI, Busy, Done, Overrun, Frame_Count, Overrun_Count
    );
`else
    modport master (
        output Din, Load,
        input  DAC_CS_n, DAC_SCLK, DAC_SDI, Busy, Done, Overrun
    );
    modport slave (
        input  Din, Load,
        output DAC_CS_n, DAC_SCLK, DAC_SDI, Busy, Done, Overrun
    );
`endif
endinterface

// File: rtl/spare_dac_serializer.sv
// Frames 12-bit spare-path words as 16-bit {CMD_BITS, data} SPI transfers with a one-deep pending slot.
// Optional frame/overrun counters are enabled by defining SPARE_DAC_FRAME_CNT_EN.
module spare_dac_serializer #(
    parameter int unsigned CLK_DIV  = 2,
    parameter logic [3:0]  CMD_BITS = 4'b0011
) (
    input logic                   Clock,
    input logic                   Reset,
    spare_dac_serializer_if.slave dac
);
    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    localparam logic [7:0] TICK_MAX = 8'(CLK_DIV - 1);

    state_t      state_reg, state_next;
    logic [7:0]  tick_reg, tick_next;
    logic [3:0]  bit_reg, bit_next;
    logic [15:0] shift_reg, shift_next;
    logic        sclk_reg, sclk_next;
    logic        cs_n_reg, cs_n_next;
    logic        sdi_reg, sdi_next;
    logic [11:0] pend_reg, pend_next;
    logic        pend_valid_reg, pend_valid_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;
    logic        overrun_reg, overrun_next;

    logic        tick;
    logic        launch;
    logic        consume_pend;
    logic        take_din;
    logic [11:0] launch_word;

    always_comb begin
        state_next      = state_reg;
        tick_next       = tick_reg;
        bit_next        = bit_reg;
        shift_next      = shift_reg;
        sclk_next       = sclk_reg;
        cs_n_next       = cs_n_reg;
        sdi_next        = sdi_reg;
        pend_next       = pend_reg;
        pend_valid_next = pend_valid_reg;
        done_next       = 1'b0;
        overrun_next    = 1'b0;
        busy_next       = 1'b0;
        launch          = 1'b0;
        consume_pend    = 1'b0;
        take_din        = 1'b0;
        launch_word     = dac.Din;
        tick            = (tick_reg == TICK_MAX);

        if (state_reg == IDLE)
            tick_next = 8'd0;
        else
            tick_next = tick ? 8'd0 : tick_reg + 8'd1;

        case (state_reg)
            IDLE: begin
                if (dac.Load) begin
                    launch   = 1'b1;
                    take_din = 1'b1;
                end
            end
            SETUP: begin
                if (tick)
                    state_next = SHIFT;
            end
            SHIFT: begin
                if (tick) begin
                    if (!sclk_reg) begin
                        sclk_next = 1'b1;
                    end else begin
                        sclk_next = 1'b0;
                        if (bit_reg == 4'd15) begin
                            state_next = HOLD;
                            cs_n_next  = 1'b1;
                            sdi_next   = 1'b0;
                            done_next  = 1'b1;
                            bit_next   = 4'd0;
                        end else begin
                            shift_next = {shift_reg[14:0], 1'b0};
                            sdi_next   = shift_reg[14];
                            bit_next   = bit_reg + 4'd1;
                        end
                    end
                end
            end
            HOLD: begin
                // bit_reg doubles as the deselect tick counter: two ticks of CS_n high
                if (tick) begin
                    if (bit_reg == 4'd1) begin
                        bit_next = 4'd0;
                        if (pend_valid_reg) begin
                            launch       = 1'b1;
                            consume_pend = 1'b1;
                            launch_word  = pend_reg;
                        end else if (dac.Load) begin
                            launch   = 1'b1;
                            take_din = 1'b1;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        bit_next = bit_reg + 4'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (launch) begin
            state_next = SETUP;
            shift_next = {CMD_BITS, launch_word};
            cs_n_next  = 1'b0;
            sdi_next   = CMD_BITS[3];
            bit_next   = 4'd0;
        end

        if (consume_pend)
            pend_valid_next = 1'b0;

        // A strobe that is not starting a frame directly lands in the pending slot
        if (dac.Load && !take_din) begin
            pend_next       = dac.Din;
            pend_valid_next = 1'b1;
            overrun_next    = pend_valid_reg && !consume_pend;
        end

        busy_next = (state_next != IDLE) || pend_valid_next;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg      <= IDLE;
            tick_reg       <= 8'd0;
            bit_reg        <= 4'd0;
            shift_reg      <= 16'd0;
            sclk_reg       <= 1'b0;
            cs_n_reg       <= 1'b1;
            sdi_reg        <= 1'b0;
            pend_reg       <= 12'd0;
            pend_valid_reg <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            tick_reg       <= tick_next;
            bit_reg        <= bit_next;
            shift_reg      <= shift_next;
            sclk_reg       <= sclk_next;
            cs_n_reg       <= cs_n_next;
            sdi_reg        <= sdi_next;
            pend_reg       <= pend_next;
            pend_valid_reg <= pend_valid_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            overrun_reg    <= overrun_next;
        end
    end

    assign dac.DAC_CS_n = cs_n_reg;
    assign dac.DAC_SCLK = sclk_reg;
    assign dac.DAC_SDI  = sdi_reg;
    assign dac.Busy     = busy_reg;
    assign dac.Done     = done_reg;
    assign dac.Overrun  = overrun_reg;

`ifdef SPARE_DAC_FRAME_CNT_EN
    logic [15:0] frame_cnt_reg;
    logic [7:0]  overrun_cnt_reg;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            frame_cnt_reg   <= 16'd0;
            overrun_cnt_reg <= 8'd0;
        end else begin
            if (done_reg)
                frame_cnt_reg <= frame_cnt_reg + 16'd1;
            if (overrun_reg && (overrun_cnt_reg != 8'hFF))
                overrun_cnt_reg <= overrun_cnt_reg + 8'd1;
        end
    end

    assign dac.Frame_Count   = frame_cnt_reg;
    assign dac.Overrun_Count = overrun_cnt_reg;
`endif
endmodule

// File: tb/tb_spare_dac_serializer.sv
// Scoreboard bench: stimulus queues expected SPI frames, per-DUT monitors decode the pins and compare.
module tb_spare_dac_serializer;
    typedef struct {
        int          dut;
        logic [15:0] frame;
        int          low;
        int          gap;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spare_dac_serializer_if if_a ();
    spare_dac_serializer_if if_b ();
    spare_dac_serializer_if if_c ();

    logic        ld   [3];
    logic [11:0] din  [3];
    logic        cs_n [3];
    logic        sclk [3];
    logic        sdi  [3];
    logic        busy [3];
    logic        done [3];
    logic        ovr  [3];

    assign if_a.Load = ld[0];
    assign if_a.Din  = din[0];
    assign if_b.Load = ld[1];
    assign if_b.Din  = din[1];
    assign if_c.Load = ld[2];
    assign if_c.Din  = din[2];

    assign cs_n[0] = if_a.DAC_CS_n;
    assign sclk[0] = if_a.DAC_SCLK;
    assign sdi[0]  = if_a.DAC_SDI;
    assign busy[0] = if_a.Busy;
    assign done[0] = if_a.Done;
    assign ovr[0]  = if_a.Overrun;
    assign cs_n[1] = if_b.DAC_CS_n;
    assign sclk[1] = if_b.DAC_SCLK;
    assign sdi[1]  = if_b.DAC_SDI;
    assign busy[1] = if_b.Busy;
    assign done[1] = if_b.Done;
    assign ovr[1]  = if_b.Overrun;
    assign cs_n[2] = if_c.DAC_CS_n;
    assign sclk[2] = if_c.DAC_SCLK;
    assign sdi[2]  = if_c.DAC_SDI;
    assign busy[2] = if_c.Busy;
    assign done[2] = if_c.Done;
    assign ovr[2]  = if_c.Overrun;

    spare_dac_serializer #(.CLK_DIV(2)) dut_a (.Clock(clk), .Reset(rst), .dac(if_a));
    spare_dac_serializer #(.CLK_DIV(1), .CMD_BITS(4'b1000)) dut_b (.Clock(clk), .Reset(rst), .dac(if_b));
    spare_dac_serializer #(.CLK_DIV(10)) dut_c (.Clock(clk), .Reset(rst), .dac(if_c));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int dut, input logic [15:0] frame, input int low, input int gap);
        exp_t e;
        e.dut   = dut;
        e.frame = frame;
        e.low   = low;
        e.gap   = gap;
        exp_q.push_back(e);
    endtask

    // Pulses Load for one cycle from a falling edge, then checks Overrun for that strobe
    task automatic do_load(input int idx, input logic [11:0] word, input logic exp_ov);
        din[idx] = word;
        ld[idx]  = 1'b1;
        @(negedge clk);
        ld[idx]  = 1'b0;
        check($sformatf("overrun_dut%0d_%03h", idx, word), 32'(ovr[idx]), 32'(exp_ov));
    endtask

    task automatic wait_done(input int idx, input int max);
        int n = 0;
        while (!done[idx] && n < max) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("done_seen_dut%0d", idx), 32'(done[idx]), 32'd1);
    endtask

    task automatic wait_idle(input int idx, input int max);
        int n = 0;
        while (busy[idx] && n < max) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("idle_reached_dut%0d", idx), 32'(busy[idx]), 32'd0);
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_mon
        bit          in_frame  = 1'b0;
        int          cs_cnt    = 0;
        int          nbits     = 0;
        int          hi_cnt    = 0;
        int          gap_meas  = 0;
        logic [15:0] bits      = 16'd0;
        logic        sclk_prev = 1'b0;
        exp_t        e;

        always @(negedge clk) begin
            if (rst) begin
                in_frame = 1'b0;
                hi_cnt   = 0;
            end else if (!cs_n[gi]) begin
                if (!in_frame) begin
                    in_frame = 1'b1;
                    cs_cnt   = 0;
                    nbits    = 0;
                    bits     = 16'd0;
                    gap_meas = hi_cnt;
                end
                cs_cnt++;
                if (sclk[gi] && !sclk_prev) begin
                    bits = {bits[14:0], sdi[gi]};
                    nbits++;
                end
            end else if (in_frame) begin
                in_frame = 1'b0;
                hi_cnt   = 1;
                check($sformatf("dut%0d_frame_expected", gi), 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    $display("dut%0d frame 0x%04h (%0d bits, cs low %0d, gap %0d)", gi, bits, nbits, cs_cnt, gap_meas);
                    check($sformatf("dut%0d_frame_owner", gi), 32'(e.dut), 32'(gi));
                    check($sformatf("dut%0d_frame_data", gi), 32'(bits), 32'(e.frame));
                    check($sformatf("dut%0d_sclk_rises", gi), 32'(nbits), 32'd16);
                    check($sformatf("dut%0d_cs_low_cycles", gi), 32'(cs_cnt), 32'(e.low));
                    check($sformatf("dut%0d_done_at_end", gi), 32'(done[gi]), 32'd1);
                    check($sformatf("dut%0d_sclk_idle", gi), 32'(sclk[gi]), 32'd0);
                    check($sformatf("dut%0d_sdi_idle", gi), 32'(sdi[gi]), 32'd0);
                    if (e.gap != 0)
                        check($sformatf("dut%0d_cs_high_gap", gi), 32'(gap_meas), 32'(e.gap));
                end
            end else begin
                hi_cnt++;
            end
            sclk_prev = sclk[gi];
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int rises;
        int ovc;
        logic prev;

        for (int i = 0; i < 3; i++) begin
            ld[i]  = 1'b0;
            din[i] = 12'd0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_cs_n_dut%0d", i), 32'(cs_n[i]), 32'd1);
            check($sformatf("rst_sclk_dut%0d", i), 32'(sclk[i]), 32'd0);
            check($sformatf("rst_sdi_dut%0d", i), 32'(sdi[i]), 32'd0);
            check($sformatf("rst_busy_dut%0d", i), 32'(busy[i]), 32'd0);
            check($sformatf("rst_done_dut%0d", i), 32'(done[i]), 32'd0);
            check($sformatf("rst_overrun_dut%0d", i), 32'(ovr[i]), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Single frame from IDLE: timing of CS_n, HOLD and Busy
        push_exp(0, 16'h3A5C, 66, 0);
        do_load(0, 12'hA5C, 1'b0);
        check("t1_cs_low_next_cycle", 32'(cs_n[0]), 32'd0);
        check("t1_busy_next_cycle", 32'(busy[0]), 32'd1);
        check("t1_sdi_first_bit", 32'(sdi[0]), 32'd0);
        wait_done(0, 200);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy[0] && n < 20);
        check("t1_hold_cycles_until_idle", 32'(n), 32'd4);

        // Word arriving mid-frame goes out right after the deselect time
        push_exp(0, 16'h3123, 66, 0);
        do_load(0, 12'h123, 1'b0);
        repeat (8) @(negedge clk);
        push_exp(0, 16'h3456, 66, 4);
        do_load(0, 12'h456, 1'b0);
        wait_idle(0, 400);

        // Second pending word overwritten by the third
        push_exp(0, 16'h3111, 66, 0);
        do_load(0, 12'h111, 1'b0);
        repeat (4) @(negedge clk);
        do_load(0, 12'h222, 1'b0);
        repeat (4) @(negedge clk);
        push_exp(0, 16'h3333, 66, 4);
        do_load(0, 12'h333, 1'b1);
        wait_idle(0, 400);

        // Reset in the middle of a frame
        push_exp(0, 16'h3FFF, 66, 0);
        do_load(0, 12'hFFF, 1'b0);
        n = 0;
        rises = 0;
        prev = sclk[0];
        while (rises < 7 && n < 300) begin
            @(negedge clk);
            n++;
            if (sclk[0] && !prev)
                rises++;
            prev = sclk[0];
        end
        check("t4_seventh_rise_seen", 32'(rises), 32'd7);
        rst = 1'b1;
        @(negedge clk);
        check("t4_rst_cs_n", 32'(cs_n[0]), 32'd1);
        check("t4_rst_sclk", 32'(sclk[0]), 32'd0);
        check("t4_rst_sdi", 32'(sdi[0]), 32'd0);
        check("t4_rst_busy", 32'(busy[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        push_exp(0, 16'h3FFF, 66, 0);
        do_load(0, 12'hFFF, 1'b0);
        wait_idle(0, 400);

        // Fastest SCLK and a different command nibble
        push_exp(1, 16'h8001, 33, 0);
        do_load(1, 12'h001, 1'b0);
        wait_idle(1, 200);

        // Load held high for 302 cycles: 300 overruns, last word survives
        push_exp(2, 16'h3400, 330, 0);
        push_exp(2, 16'h352D, 330, 20);
        din[2] = 12'h400;
        ld[2] = 1'b1;
        ovc = 0;
        for (int k = 1; k <= 301; k++) begin
            @(negedge clk);
            if (ovr[2])
                ovc++;
            din[2] = 12'(12'h400 + k);
        end
        @(negedge clk);
        ld[2] = 1'b0;
        if (ovr[2])
            ovc++;
        check("t6_overrun_pulses", 32'(ovc), 32'd300);
        wait_idle(2, 2000);
        push_exp(2, 16'h37E7, 330, 0);
        do_load(2, 12'h7E7, 1'b0);
        wait_idle(2, 1000);
`ifdef SPARE_DAC_FRAME_CNT_EN
        check("t6_frame_count", 32'(if_c.Frame_Count), 32'd3);
        check("t6_overrun_count_saturated", 32'(if_c.Overrun_Count), 32'hFF);
        check("a_frame_count", 32'(if_a.Frame_Count), 32'd1);
        check("a_overrun_count", 32'(if_a.Overrun_Count), 32'd0);
`endif

        repeat (5) @(negedge clk);
        check("expected_frames_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
